rv_dmem_bridge: RTL

- Data-memory responder for the core's load/store path.
- Accepts load/store requests issued by the execute stage and runs a single Wishbone-classic bus cycle for each one.
- Returns the raw 32-bit read word and one-cycle load/store completion strobes; the writeback stage consumes these as its load data and done inputs.
- Adds a bus timeout and error reporting so a dead slave cannot hang the pipeline.

---
 rtl/rv_dmem_bridge.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/rv_dmem_bridge.sv
// ---------------------------------------------------------------------------
// rv_dmem_bridge
//
// Data-memory responder for the core's load/store path. Each load or store
// request from the execute stage becomes exactly one Wishbone-classic bus
// cycle. The raw 32-bit read word and single-cycle completion strobes are
// handed back to the writeback stage. A bus timeout makes sure a dead slave
// cannot stall the pipeline forever.
//
// Parameters
//   TIMEOUT_CYCLES : stb-high cycles to wait for ack/err before the cycle is
//                    forcibly terminated as an error (0 disables the timeout)
//   ERR_DATA       : word returned on dm_data_l_o when a load errors out
//
// Ports
//   clk_i, rst_n_i      : core clock, asynchronous active-low reset
//   dm_addr_i           : byte address of the request
//   dm_data_s_i         : store data, already lane aligned
//   dm_data_select_i    : byte lane enables for stores
//   dm_load_i           : load request pulse
//   dm_store_i          : store request pulse (wins over a coincident load)
//   dm_ready_o          : high while idle and able to accept a request
//   dm_data_l_o         : raw read word of the most recent completed load
//   dm_load_done_o      : one-cycle load completion strobe
//   dm_store_done_o     : one-cycle store completion strobe
//   dm_bus_error_o      : one-cycle error strobe, coincident with done
//   bus_cyc_o/bus_stb_o : Wishbone cycle / strobe
//   bus_we_o            : Wishbone write enable
//   bus_adr_o           : word-aligned Wishbone address
//   bus_sel_o           : Wishbone byte selects
//   bus_dat_o           : Wishbone write data
//   bus_dat_i           : Wishbone read data
//   bus_ack_i/bus_err_i : slave acknowledge / slave error
// ---------------------------------------------------------------------------
module rv_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_bus_error_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i,
  input  logic        bus_err_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Counter value on which the timeout fires; the counter is 0 in the first
  // stb-high cycle, so firing on TIMEOUT_CYCLES-1 gives exactly
  // TIMEOUT_CYCLES stb-high cycles before the forced termination.
  localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_cyc;
  logic        w_cyc_nxt;
  logic        r_we;
  logic        w_we_nxt;
  logic [31:0] r_adr;
  logic [31:0] w_adr_nxt;
  logic [3:0]  r_sel;
  logic [3:0]  w_sel_nxt;
  logic [31:0] r_dat;
  logic [31:0] w_dat_nxt;
  logic [31:0] r_data_l;
  logic [31:0] w_data_l_nxt;
  logic        r_load_done;
  logic        w_load_done_nxt;
  logic        r_store_done;
  logic        w_store_done_nxt;
  logic        r_bus_error;
  logic        w_bus_error_nxt;
  logic [31:0] r_tmo;
  logic [31:0] w_tmo_nxt;

  logic        w_tmo_hit;
  logic        w_finish;
  logic        w_fail;
  logic        w_unused;

  // The low address bits only matter to the writeback byte/half extraction.
  assign w_unused = &{1'b0, dm_addr_i[1:0]};

  // An err (or a timeout not rescued by an ack in the same cycle) ends the
  // cycle as a failure; err beats a simultaneous ack.
  assign w_tmo_hit = TMO_EN && (r_tmo == TMO_LAST);
  assign w_finish  = bus_ack_i | bus_err_i | w_tmo_hit;
  assign w_fail    = bus_err_i | (~bus_ack_i & w_tmo_hit);

  assign dm_ready_o      = (r_state == IDLE);
  assign bus_cyc_o       = r_cyc;
  assign bus_stb_o       = r_cyc;
  assign bus_we_o        = r_we;
  assign bus_adr_o       = r_adr;
  assign bus_sel_o       = r_sel;
  assign bus_dat_o       = r_dat;
  assign dm_data_l_o     = r_data_l;
  assign dm_load_done_o  = r_load_done;
  assign dm_store_done_o = r_store_done;
  assign dm_bus_error_o  = r_bus_error;

  always_comb begin
    w_state_nxt      = r_state;
    w_cyc_nxt        = r_cyc;
    w_we_nxt         = r_we;
    w_adr_nxt        = r_adr;
    w_sel_nxt        = r_sel;
    w_dat_nxt        = r_dat;
    w_data_l_nxt     = r_data_l;
    w_load_done_nxt  = 1'b0;
    w_store_done_nxt = 1'b0;
    w_bus_error_nxt  = 1'b0;
    w_tmo_nxt        = r_tmo;

    case (r_state)
      IDLE: begin
        // Ack/err seen here belong to nobody and are ignored.
        if (dm_store_i) begin
          w_adr_nxt   = {dm_addr_i[31:2], 2'b00};
          w_dat_nxt   = dm_data_s_i;
          w_sel_nxt   = dm_data_select_i;
          w_we_nxt    = 1'b1;
          w_cyc_nxt   = 1'b1;
          w_tmo_nxt   = 32'd0;
          w_state_nxt = BUSY;
        end else if (dm_load_i) begin
          w_adr_nxt   = {dm_addr_i[31:2], 2'b00};
          w_sel_nxt   = 4'hF;
          w_we_nxt    = 1'b0;
          w_cyc_nxt   = 1'b1;
          w_tmo_nxt   = 32'd0;
          w_state_nxt = BUSY;
        end
      end

      BUSY: begin
        // Request inputs are deliberately not looked at while busy.
        if (w_finish) begin
          w_state_nxt     = IDLE;
          w_cyc_nxt       = 1'b0;
          w_we_nxt        = 1'b0;
          w_bus_error_nxt = w_fail;
          if (r_we) begin
            w_store_done_nxt = 1'b1;
          end else begin
            w_load_done_nxt = 1'b1;
            w_data_l_nxt    = w_fail ? ERR_DATA : bus_dat_i;
          end
        end else begin
          w_tmo_nxt = r_tmo + 32'd1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cyc_nxt   = 1'b0;
        w_we_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_cyc        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= 32'd0;
      r_sel        <= 4'd0;
      r_dat        <= 32'd0;
      r_data_l     <= 32'd0;
      r_load_done  <= 1'b0;
      r_store_done <= 1'b0;
      r_bus_error  <= 1'b0;
      r_tmo        <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cyc        <= w_cyc_nxt;
      r_we         <= w_we_nxt;
      r_adr        <= w_adr_nxt;
      r_sel        <= w_sel_nxt;
      r_dat        <= w_dat_nxt;
      r_data_l     <= w_data_l_nxt;
      r_load_done  <= w_load_done_nxt;
      r_store_done <= w_store_done_nxt;
      r_bus_error  <= w_bus_error_nxt;
      r_tmo        <= w_tmo_nxt;
    end
  end

endmodule
